// File: rtl/base9_pkg.sv
// Shared constants, state encoding and digit saturation for the base-9 BCD counters.
package base9_pkg;

    localparam int              DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE_ST = 2'b10
    } state_t;

    // Clamp a raw nibble into the legal base-9 range 0..8.
    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/base9_digit_dec.sv
// One base-9 digit slice: loadable nibble that decrements on borrow-in and wraps 0 -> 8.
module base9_digit_dec
    import base9_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_load_digit,
    input  logic               i_borrow_in,
    output logic               o_borrow_out,
    output logic [DIGIT_W-1:0] o_digit
);

    logic [DIGIT_W-1:0] r_digit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= i_load_digit;
        end else if (i_borrow_in) begin
            r_digit <= (r_digit == '0) ? DIGIT_MAX : (r_digit - 4'd1);
        end
    end

    assign o_borrow_out = i_borrow_in & (r_digit == '0);
    assign o_digit      = r_digit;

endmodule

// File: rtl/base9_down_counter.sv
// Multi-digit base-9 BCD down-counter with stop-at-zero and a one-cycle DONE pulse.
// Optional macro BASE9_AUTO_RELOAD_EN: reload the last preset instead of stopping at zero.
module base9_down_counter
    import base9_pkg::*;
#(
    parameter int NUM_DIGITS = 2
)
(
    input  logic                          CLK,
    input  logic                          R,
    input  logic                          LOAD,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] LOAD_VAL,
    input  logic                          EN,
    output logic [DIGIT_W*NUM_DIGITS-1:0] COUNT,
    output logic                          ZERO,
    output logic                          BUSY,
    output logic                          DONE
);

    localparam int CW = DIGIT_W * NUM_DIGITS;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_done;
    logic            w_done_next;
    logic            w_reload_hit;
    logic            w_reload_nz;
    logic            w_seg_load;
    logic            w_dec;
    logic            w_count_is_one;
    logic            w_unused_borrow;
    logic [CW-1:0]   w_load_sat;
    logic [CW-1:0]   w_load_digits;
    logic [CW-1:0]   w_count;
    logic [NUM_DIGITS:0] w_borrow;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sat
            assign w_load_sat[gi*DIGIT_W +: DIGIT_W] = sat_digit(LOAD_VAL[gi*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

`ifdef BASE9_AUTO_RELOAD_EN
    logic [CW-1:0] r_reload;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_reload <= '0;
        end else if (LOAD) begin
            r_reload <= w_load_sat;
        end
    end

    assign w_reload_nz   = |r_reload;
    assign w_load_digits = LOAD ? w_load_sat : r_reload;
`else
    assign w_reload_nz   = 1'b0;
    assign w_load_digits = w_load_sat;
`endif

    // A reload at the terminal count reuses the digit load path.
    assign w_seg_load     = LOAD | w_reload_hit;
    assign w_dec          = (r_state == RUN) & EN & ~w_seg_load;
    assign w_borrow[0]    = w_dec;
    assign w_count_is_one = (w_count == {{(CW-1){1'b0}}, 1'b1});

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            base9_digit_dec u_digit (
                .i_clk        (CLK),
                .i_rst_n      (R),
                .i_load       (w_seg_load),
                .i_load_digit (w_load_digits[gi*DIGIT_W +: DIGIT_W]),
                .i_borrow_in  (w_borrow[gi]),
                .o_borrow_out (w_borrow[gi+1]),
                .o_digit      (w_count[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // RUN never decrements from zero, so the top borrow never fires.
    assign w_unused_borrow = w_borrow[NUM_DIGITS];

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_reload_hit = 1'b0;
        if (LOAD) begin
            w_state_next = (w_load_sat != '0) ? RUN : IDLE;
        end else begin
            case (r_state)
                RUN: begin
                    if (EN && w_count_is_one) begin
                        w_done_next = 1'b1;
                        if (w_reload_nz) begin
                            w_reload_hit = 1'b1;
                        end else begin
                            w_state_next = DONE_ST;
                        end
                    end
                end
                DONE_ST: w_state_next = IDLE;
                IDLE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign COUNT = w_count;
    assign ZERO  = (w_count == '0);
    assign BUSY  = (r_state == RUN);
    assign DONE  = r_done;

endmodule
